// File: rtl/i2c_reg_config_seq.sv
// i2c_reg_config_seq: walks a register ROM of 3-byte entries {addr_hi, addr_lo, data}
// and issues one 3-byte write transaction per entry to the I2C master wrapper.
// Optional macro I2C_CFG_DELAY_EN: entries whose address equals DELAY_MARKER are
// not sent; instead they stall the sequence for data*SYSCLK_FREQ*1000 cycles.
module i2c_reg_config_seq #(
  parameter int          NUM_ENTRIES  = 306,
  parameter int          ROM_AW       = 10,
  parameter int          GAP_CYCLES   = 16,
  parameter int          ACK_TIMEOUT  = 4096,
  parameter int          SYSCLK_FREQ  = 100,
  parameter logic [15:0] DELAY_MARKER = 16'hFFFF
) (
  input  logic              r_sysclk,
  input  logic              r_arst,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  output logic [8:0]        o_entry_cnt,
  output logic [ROM_AW-1:0] o_rom_addr,
  input  logic [7:0]        i_rom_data,
  output logic              o_m_en,
  output logic              o_m_wr,
  output logic              o_m_last,
  output logic [7:0]        o_m_data,
  input  logic              i_m_ack
);

  typedef enum logic [3:0] {
    IDLE, FETCH, CHECK, SEND, STOP, GAP,
`ifdef I2C_CFG_DELAY_EN
    DELAY,
`endif
    DONE, ERR
  } state_t;

  state_t      state, state_nxt;
  logic [23:0] ent;       // current entry; the byte on the wire is always ent[23:16]
  logic [1:0]  idx;       // byte index within FETCH / SEND
  logic [31:0] cnt;       // ack timeout (up), gap and delay (down)
  logic        err_last;  // one-cycle STOP request on entering ERR

  logic last_entry, timeout;
  assign last_entry = (o_entry_cnt + 9'd1) == 9'(NUM_ENTRIES);
  assign timeout    = cnt == 32'(ACK_TIMEOUT - 1);

`ifdef I2C_CFG_DELAY_EN
  logic is_marker;
  assign is_marker = ent[23:8] == DELAY_MARKER;
`endif

  // state register
  always_ff @(posedge r_sysclk or posedge r_arst) begin
    if (r_arst) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state decode; an ack in the same cycle as the timeout wins
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE, ERR: if (i_start) state_nxt = (NUM_ENTRIES == 0) ? DONE : FETCH;
      FETCH: if (idx == 2'd2) state_nxt = CHECK;
      CHECK: begin
        state_nxt = SEND;
`ifdef I2C_CFG_DELAY_EN
        if (is_marker) state_nxt = DELAY;
`endif
      end
      SEND: begin
        if (i_m_ack) begin
          if (idx == 2'd2) state_nxt = STOP;
        end else if (timeout) begin
          state_nxt = ERR;
        end
      end
      STOP: state_nxt = last_entry ? DONE : GAP;
      GAP:  if (cnt == 32'd0) state_nxt = FETCH;
`ifdef I2C_CFG_DELAY_EN
      DELAY: if (cnt == 32'd0) state_nxt = last_entry ? DONE : GAP;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // outputs decode straight from state so an async reset drops them at once
  always_comb begin
    o_busy   = !(state == IDLE || state == DONE || state == ERR);
    o_done   = state == DONE;
    o_error  = state == ERR;
    o_m_en   = state == SEND;
    o_m_wr   = 1'b0;
    o_m_last = (state == STOP) || err_last;
    o_m_data = (state == SEND) ? ent[23:16] : 8'h00;
  end

  // datapath: ROM address, entry shift register, counters
  always_ff @(posedge r_sysclk or posedge r_arst) begin
    if (r_arst) begin
      o_entry_cnt <= '0;
      o_rom_addr  <= '0;
      ent         <= '0;
      idx         <= '0;
      cnt         <= '0;
      err_last    <= 1'b0;
    end else begin
      err_last <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (i_start) begin
            o_entry_cnt <= '0;
            o_rom_addr  <= '0;
            idx         <= '0;
          end
        end
        FETCH: begin
          ent        <= {ent[15:0], i_rom_data};
          o_rom_addr <= o_rom_addr + 1'b1;
          idx        <= idx + 2'd1;
        end
        CHECK: begin
          idx <= '0;
          cnt <= '0;
`ifdef I2C_CFG_DELAY_EN
          // zero milliseconds still costs one DELAY cycle
          if (is_marker)
            cnt <= (ent[7:0] == 8'd0) ? 32'd0
                 : ({24'd0, ent[7:0]} * 32'(SYSCLK_FREQ) * 32'd1000) - 32'd1;
`endif
        end
        SEND: begin
          if (i_m_ack) begin
            ent <= {ent[15:0], 8'h00};
            idx <= idx + 2'd1;
            cnt <= '0;
          end else if (timeout) begin
            err_last <= 1'b1;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        STOP: begin
          o_entry_cnt <= o_entry_cnt + 9'd1;
          idx         <= '0;
          cnt         <= 32'(GAP_CYCLES - 1);
        end
        GAP: if (cnt != 32'd0) cnt <= cnt - 32'd1;
`ifdef I2C_CFG_DELAY_EN
        DELAY: begin
          if (cnt == 32'd0) begin
            o_entry_cnt <= o_entry_cnt + 9'd1;
            cnt         <= 32'(GAP_CYCLES - 1);
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_reg_config_seq.sv
// Directed bench for i2c_reg_config_seq with a byte scoreboard and an acking master model.
module tb_i2c_reg_config_seq;

`ifdef I2C_CFG_DELAY_EN
  localparam int NE = 3;
  localparam int MAX_RUN = 2017;  // STOP+GAP+FETCH+CHECK+2000 delay+GAP+FETCH+CHECK
`else
  localparam int NE = 2;
  localparam int MAX_RUN = 9;     // STOP+GAP(4)+FETCH(3)+CHECK
`endif

  logic       r_sysclk = 0, r_arst, i_start, i_m_ack;
  logic       o_busy, o_done, o_error, o_m_en, o_m_wr, o_m_last;
  logic [8:0] o_entry_cnt;
  logic [5:0] o_rom_addr;
  logic [7:0] i_rom_data, o_m_data;

  logic       i_start0;
  logic       o_busy0, o_done0, o_error0, o_m_en0, o_m_wr0, o_m_last0;
  logic [8:0] o_entry_cnt0;
  logic [5:0] o_rom_addr0;
  logic [7:0] o_m_data0;

  always #5 r_sysclk = ~r_sysclk;

  i2c_reg_config_seq #(.NUM_ENTRIES(NE), .ROM_AW(6), .GAP_CYCLES(4), .ACK_TIMEOUT(64),
                       .SYSCLK_FREQ(1), .DELAY_MARKER(16'hFFFF)) dut (
    .r_sysclk(r_sysclk), .r_arst(r_arst), .i_start(i_start), .o_busy(o_busy),
    .o_done(o_done), .o_error(o_error), .o_entry_cnt(o_entry_cnt), .o_rom_addr(o_rom_addr),
    .i_rom_data(i_rom_data), .o_m_en(o_m_en), .o_m_wr(o_m_wr), .o_m_last(o_m_last),
    .o_m_data(o_m_data), .i_m_ack(i_m_ack));

  i2c_reg_config_seq #(.NUM_ENTRIES(0), .ROM_AW(6), .GAP_CYCLES(4), .ACK_TIMEOUT(64),
                       .SYSCLK_FREQ(1), .DELAY_MARKER(16'hFFFF)) dut0 (
    .r_sysclk(r_sysclk), .r_arst(r_arst), .i_start(i_start0), .o_busy(o_busy0),
    .o_done(o_done0), .o_error(o_error0), .o_entry_cnt(o_entry_cnt0), .o_rom_addr(o_rom_addr0),
    .i_rom_data(8'h00), .o_m_en(o_m_en0), .o_m_wr(o_m_wr0), .o_m_last(o_m_last0),
    .o_m_data(o_m_data0), .i_m_ack(1'b0));

  logic [7:0] rom [0:63];
  always_comb i_rom_data = rom[o_rom_addr];

  int n_tests = 0, n_fail = 0;
  logic [7:0] sb_q[$];
  int stall_at = -1, byte_no = 0, wait_n = 0;
  int en_hi = 0, last_cnt = 0, low_run = 0, max_run = 0;
  bit seen_en = 0, en0_seen = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_tx();
    sb_q.push_back(8'h30); sb_q.push_back(8'h08); sb_q.push_back(8'h82);
    sb_q.push_back(8'h30); sb_q.push_back(8'h08); sb_q.push_back(8'h02);
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    @(negedge r_sysclk);
    i_start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 6000 && !o_done; i++) @(negedge r_sysclk);
    chk(tag, {31'd0, o_done}, 32'd1);
  endtask

  // master model: acks each byte 3 cycles after o_m_en, checks data against the scoreboard
  initial begin
    i_m_ack = 1'b0;
    forever begin
      @(negedge r_sysclk);
      i_m_ack = 1'b0;
      if (o_last_seen()) last_cnt++;
      if (o_m_en0) en0_seen = 1'b1;
      if (o_m_en) begin
        en_hi++;
        if (seen_en && low_run > max_run) max_run = low_run;
        low_run = 0;
        seen_en = 1'b1;
        wait_n++;
        if (wait_n >= 3 && byte_no != stall_at) begin
          chk("sb_nonempty", {31'd0, sb_q.size() > 0}, 32'd1);
          if (sb_q.size() > 0) chk("m_data", {24'd0, o_m_data}, {24'd0, sb_q.pop_front()});
          i_m_ack = 1'b1;
          wait_n  = 0;
          byte_no++;
        end
      end else begin
        wait_n = 0;
        if (seen_en) low_run++;
      end
    end
  end

  function automatic bit o_last_seen();
    return o_m_last;
  endfunction

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 8'h00;
    rom[0] = 8'h30; rom[1] = 8'h08; rom[2] = 8'h82;
`ifdef I2C_CFG_DELAY_EN
    rom[3] = 8'hFF; rom[4] = 8'hFF; rom[5] = 8'h02;
    rom[6] = 8'h30; rom[7] = 8'h08; rom[8] = 8'h02;
`else
    rom[3] = 8'h30; rom[4] = 8'h08; rom[5] = 8'h02;
`endif
    r_arst = 1'b1; i_start = 1'b0; i_start0 = 1'b0;
    repeat (3) @(negedge r_sysclk);
    chk("reset_outs", {2'd0, o_busy, o_done, o_error, o_entry_cnt, o_rom_addr, o_m_en,
                       o_m_wr, o_m_last, o_m_data}, 32'd0);
    chk("reset_done0", {31'd0, o_done0}, 32'd0);
    r_arst = 1'b0;
    @(negedge r_sysclk);

    // normal sequence, with a stray start while busy
    push_tx(); last_cnt = 0; seen_en = 0; max_run = 0;
    pulse_start();
    chk("busy_after_start", {31'd0, o_busy}, 32'd1);
    repeat (20) @(negedge r_sysclk);
    pulse_start();
    wait_done("done1");
    chk("busy1", {31'd0, o_busy}, 32'd0);
    chk("entry_cnt1", {23'd0, o_entry_cnt}, NE);
    chk("rom_addr1", {26'd0, o_rom_addr}, 3 * NE);
    chk("last_pulses1", last_cnt, 2);
    chk("sb_drained1", sb_q.size(), 0);
    chk("max_gap1", max_run, MAX_RUN);
    chk("wr_low", {31'd0, o_m_wr}, 32'd0);

    // replay from DONE
    push_tx();
    pulse_start();
    chk("replay_clear", {o_done, o_busy, o_entry_cnt, o_rom_addr}, {2'b01, 9'd0, 6'd0});
    wait_done("done2");
    chk("entry_cnt2", {23'd0, o_entry_cnt}, NE);
    chk("sb_drained2", sb_q.size(), 0);

    // ack timeout on the second byte of entry 0
    byte_no = 0; stall_at = 1; en_hi = 0; last_cnt = 0;
    sb_q.push_back(8'h30);
    pulse_start();
    for (int i = 0; i < 500 && !o_error; i++) @(negedge r_sysclk);
    chk("error_set", {31'd0, o_error}, 32'd1);
    repeat (3) @(negedge r_sysclk);
    chk("err_flags", {o_busy, o_done, o_m_en}, 3'b000);
    chk("err_entry_cnt", {23'd0, o_entry_cnt}, 32'd0);
    chk("err_last_pulses", last_cnt, 1);
    chk("err_en_cycles", en_hi, 3 + 64);
    stall_at = -1;

    // async reset mid-transaction
    sb_q.delete(); push_tx();
    pulse_start();
    for (int i = 0; i < 6000 && !(o_entry_cnt >= 9'd1 && o_m_en); i++) @(negedge r_sysclk);
    chk("reach_entry1", {31'd0, o_m_en}, 32'd1);
    r_arst = 1'b1;
    #1;
    chk("arst_outs", {2'd0, o_busy, o_done, o_error, o_entry_cnt, o_rom_addr, o_m_en,
                      o_m_wr, o_m_last, o_m_data}, 32'd0);
    @(negedge r_sysclk);
    sb_q.delete();
    r_arst = 1'b0;
    @(negedge r_sysclk);
    push_tx();
    pulse_start();
    chk("restart_addr", {26'd0, o_rom_addr}, 32'd0);
    wait_done("done3");
    chk("entry_cnt3", {23'd0, o_entry_cnt}, NE);
    chk("sb_drained3", sb_q.size(), 0);

    // empty table
    i_start0 = 1'b1;
    @(negedge r_sysclk);
    i_start0 = 1'b0;
    chk("empty_done", {o_done0, o_busy0}, 2'b10);
    repeat (5) @(negedge r_sysclk);
    chk("empty_no_en", {31'd0, en0_seen}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
